tbs_tx: RTL
===========

TBS_TX -- requirements
Module: tbs_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, TBS bit rate.
REQ-003 Parameter PULSE_CYCLES, default 81, low-pulse width in clocks for a '0' bit (about 3/16 of a bit period).
REQ-004 clk_50M  input  1  system clock; single clock domain.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 tx_data  input  8  byte to transmit; sampled only on acceptance.
REQ-007 tx_valid  input  1  tx_data is valid.
REQ-008 tx_ready  output  1  block can accept a byte.
REQ-009 tx_busy  output  1  frame in progress.
REQ-010 TBS_out  output  1  TBS bus drive; idle high.

Function
REQ-011 BIT_PERIOD_COUNT SHALL equal CLK_FREQ/BAUD_RATE with integer division: 434 at the default parameters.
REQ-012 Elaboration SHALL fail unless 2 <= PULSE_CYCLES < BIT_PERIOD_COUNT.
REQ-013 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-014 tx_ready SHALL be 1 only in IDLE; tx_busy SHALL be the inverse of tx_ready.
REQ-015 A byte SHALL be accepted on a cycle with tx_valid=1 and tx_ready=1: tx_data is latched and the FSM goes IDLE->START.
REQ-016 tx_valid SHALL be ignored outside IDLE; tx_data changes after acceptance SHALL have no effect.
REQ-017 Frame: 1 start bit ('0'), then 8 data bits LSB first, then 1 stop bit ('1'); each bit lasts exactly BIT_PERIOD_COUNT clocks.
REQ-018 Bit encoding: a '0' bit drives TBS_out low for clocks 0..PULSE_CYCLES-1 of its bit period and high for the rest; a '1' bit drives high for the whole period.
REQ-019 TBS_out SHALL be registered; its first low clock SHALL be the clock after acceptance (latency 1).
REQ-020 A cycle counter SHALL run 0..BIT_PERIOD_COUNT-1 and wrap; a 3-bit bit index SHALL count 0..7 in DATA.
REQ-021 Transitions:
- START->DATA on counter wrap.
- DATA->STOP on wrap at index 7.
- STOP->IDLE on wrap.
REQ-022 Frame length SHALL be 10*BIT_PERIOD_COUNT clocks (4340 at defaults).
REQ-023 With tx_valid held high, consecutive start falling edges SHALL be 10*BIT_PERIOD_COUNT+1 clocks apart (one IDLE cycle between frames).
REQ-024 Outside '0'-bit pulse windows, TBS_out SHALL be 1, including in IDLE and STOP.

Reset
REQ-025 While rst_n=0: state=IDLE, TBS_out=1, tx_ready=1, tx_busy=0, counters=0, data register=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame, with TBS_out going high asynchronously.
REQ-027 The first byte after reset release SHALL be accepted and sent as a complete frame.

Structure
REQ-028 A shared package/include tbs_defs SHALL hold:
- BIT_PERIOD_COUNT derivation
- the PULSE_CYCLES default
- FSM state encodings
These are shared with the TBS receive path.
REQ-029 One sub-module, tbs_bit_timer, SHALL provide the cycle counter with bit_end and pulse_active outputs; the FSM and data shift register stay in tbs_tx.

Verification
REQ-030 Reset: hold rst_n=0 with tx_valid=1 -> TBS_out=1, tx_ready=1, tx_busy=0, and no acceptance.
REQ-031 Send 0x55 -> low pulses of 81 clocks at bit periods 0 (start), 2, 4, 6, 8; tx_ready returns 4341 clocks after acceptance.
REQ-032 Send 0xFF -> only the start pulse; send 0x00 -> 9 pulses, each 81 clocks, at 434-clock spacing.
REQ-033 Two bytes back-to-back with tx_valid held -> the second start falling edge is 4341 clocks after the first; the second byte is captured intact.
REQ-034 Assert rst_n=0 during data bit 3 -> TBS_out=1 in the same cycle; after release, 0xA5 is sent with correct pulse positions.
REQ-035 Loopback tbs_tx -> TBS receive path -> UART receiver with 256 random bytes -> all bytes received equal, no framing errors.

Source files
------------

// File: rtl/tbs_defs.sv
// -----------------------------------------------------------------------------
// tbs_defs -- definitions shared by the TBS transmit and receive paths.
//   * Default clock, baud rate and low-pulse width.
//   * calc_bit_period(): clocks per TBS bit (integer division).
//   * FSM state encodings.
// -----------------------------------------------------------------------------
package tbs_defs;

    localparam int DEFAULT_CLK_FREQ     = 50_000_000;
    localparam int DEFAULT_BAUD_RATE    = 115200;
    localparam int DEFAULT_PULSE_CYCLES = 81;

    // Clocks per TBS bit. This is truncated, so the bit rate comes out
    // slightly fast rather than slow.
    function automatic int calc_bit_period(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/tbs_bit_timer.sv
// -----------------------------------------------------------------------------
// tbs_bit_timer -- bit-period cycle counter for the TBS transmitter.
//   clk_50M      in  system clock
//   rst_n        in  asynchronous active-low reset
//   run          in  1 while a frame is in progress; the counter is held at 0
//                    otherwise
//   bit_end      out 1 on the last clock of a bit period (the counter wraps)
//   pulse_active out 1 when the clock after this one lies inside the low-pulse
//                    window (counter value < PULSE_CYCLES)
// -----------------------------------------------------------------------------
module tbs_bit_timer #(
    parameter int BIT_PERIOD_COUNT = 434,
    parameter int PULSE_CYCLES     = 81
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic run,
    output logic bit_end,
    output logic pulse_active
);

    localparam int CNT_W = (BIT_PERIOD_COUNT > 1) ? $clog2(BIT_PERIOD_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_PERIOD_COUNT - 1);
    localparam logic [CNT_W-1:0] PULSE_LIM = CNT_W'(PULSE_CYCLES);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        bit_end = run && (cnt_reg == CNT_LAST);
        if (!run || (cnt_reg == CNT_LAST)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
        // The output register in the parent samples this together with the
        // next state. The test therefore looks at the upcoming count.
        pulse_active = (cnt_next < PULSE_LIM);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/tbs_tx.sv
// -----------------------------------------------------------------------------
// tbs_tx -- TBS serial transmitter.
// Frame: start bit '0', 8 data bits LSB first, stop bit '1'. A '0' bit is a
// low pulse of PULSE_CYCLES clocks at the start of its bit period. A '1' bit
// and idle are high.
//   clk_50M  in  system clock
//   rst_n    in  asynchronous active-low reset
//   tx_data  in  [7:0] byte to send, latched on acceptance
//   tx_valid in  tx_data valid; only looked at in IDLE
//   tx_ready out 1 in IDLE (can accept a byte)
//   tx_busy  out frame in progress (~tx_ready)
//   TBS_out  out registered bus drive, idle high
// -----------------------------------------------------------------------------
module tbs_tx
    import tbs_defs::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE    = DEFAULT_BAUD_RATE,
    parameter int PULSE_CYCLES = DEFAULT_PULSE_CYCLES
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       TBS_out
);

    localparam int BIT_PERIOD_COUNT = calc_bit_period(CLK_FREQ, BAUD_RATE);

    generate
        if ((PULSE_CYCLES < 2) || (PULSE_CYCLES >= BIT_PERIOD_COUNT)) begin : g_bad_params
            $error("tbs_tx: PULSE_CYCLES must satisfy 2 <= PULSE_CYCLES < BIT_PERIOD_COUNT");
        end
    endgenerate

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [7:0] data_reg;
    logic [7:0] data_next;
    logic [2:0] bit_idx_reg;
    logic [2:0] bit_idx_next;
    logic       tbs_out_reg;
    logic       tbs_out_next;
    logic       bit_zero_next;
    logic       timer_run;
    logic       bit_end;
    logic       pulse_active;

    assign timer_run = (state_reg != ST_IDLE);

    tbs_bit_timer #(
        .BIT_PERIOD_COUNT (BIT_PERIOD_COUNT),
        .PULSE_CYCLES     (PULSE_CYCLES)
    ) u_bit_timer (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .run          (timer_run),
        .bit_end      (bit_end),
        .pulse_active (pulse_active)
    );

    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        bit_idx_next = bit_idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (tx_valid) begin
                    data_next  = tx_data;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_idx_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        // The bit being sent is always in data_reg[0].
                        data_next    = {1'b0, data_reg[7:1]};
                    end
                end
            end
            default: begin  // ST_STOP
                if (bit_end) begin
                    state_next = ST_IDLE;
                end
            end
        endcase

        // The output is registered, so it is computed from the state the FSM
        // is about to enter. This makes the start pulse begin on the clock
        // straight after acceptance.
        bit_zero_next = (state_next == ST_START) ||
                        ((state_next == ST_DATA) && !data_next[0]);
        tbs_out_next  = !(bit_zero_next && pulse_active);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            data_reg    <= 8'd0;
            bit_idx_reg <= 3'd0;
            tbs_out_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            bit_idx_reg <= bit_idx_next;
            tbs_out_reg <= tbs_out_next;
        end
    end

    assign tx_ready = (state_reg == ST_IDLE);
    assign tx_busy  = !tx_ready;
    assign TBS_out  = tbs_out_reg;

endmodule
